// File: rtl/rename_reg_file_ckpt.sv
// Architectural register file plus register alias table (busy bit + ROB tag per register)
// with NCKPT branch checkpoints of the rename map for selective mispredict recovery.
module rename_reg_file_ckpt #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    parameter int NRP   = 2,
    parameter int NCDB  = 2,
    parameter int NCKPT = 4,
    localparam int RW   = $clog2(NREG),
    localparam int CK_W = $clog2(NCKPT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic [NRP*RW-1:0]     rs_idx,
    output logic [NRP*XLEN-1:0]   rs_val,
    output logic [NRP-1:0]        rs_rdy,
    output logic [NRP*TAG_W-1:0]  rs_tag,
    output logic [NRP*TAG_W-1:0]  rob_q_tag,
    input  logic [NRP-1:0]        rob_q_rdy,
    input  logic [NRP*XLEN-1:0]   rob_q_val,
    input  logic [NCDB-1:0]       cdb_flag,
    input  logic [NCDB*TAG_W-1:0] cdb_tag,
    input  logic [NCDB*XLEN-1:0]  cdb_val,
    input  logic                  cmt_flag,
    input  logic [RW-1:0]         cmt_rd,
    input  logic [TAG_W-1:0]      cmt_tag,
    input  logic [XLEN-1:0]       cmt_val,
    input  logic                  rnm_flag,
    input  logic [RW-1:0]         rnm_rd,
    input  logic [TAG_W-1:0]      rnm_tag,
    input  logic                  ckpt_save,
    output logic [CK_W-1:0]       ckpt_id,
    output logic                  ckpt_full,
    input  logic                  ckpt_restore,
    input  logic [CK_W-1:0]       ckpt_restore_id,
    input  logic                  ckpt_release,
    input  logic [CK_W-1:0]       ckpt_release_id
);

    logic [XLEN-1:0]  reg_val [NREG];
    logic [NREG-1:0]  busy;
    logic [TAG_W-1:0] tag     [NREG];

    logic [NCKPT-1:0] ck_valid;
    logic [NCKPT-1:0] ck_older [NCKPT];
    logic [NREG-1:0]  ck_busy  [NCKPT];
    logic [TAG_W-1:0] ck_tag   [NCKPT][NREG];

    logic [NREG-1:0]  busy_n;
    logic [TAG_W-1:0] tag_n      [NREG];
    logic [NCKPT-1:0] valid_n;
    logic [NCKPT-1:0] older_n    [NCKPT];
    logic [NREG-1:0]  ck_busy_n  [NCKPT];
    logic [TAG_W-1:0] ck_tag_n   [NCKPT][NREG];

    logic             rnm_en;
    logic             save_en;
    logic [NCKPT-1:0] rel_mask;
    logic [CK_W-1:0]  free_id;

    // ---------------- combinational read ports (pre-update state) ----------------
    for (genvar gp = 0; gp < NRP; gp++) begin : g_rd
        logic [RW-1:0]    idx;
        logic [TAG_W-1:0] mtag;
        logic             cdb_hit;
        logic [XLEN-1:0]  cdb_v;
        logic [XLEN-1:0]  val;
        logic             ok;

        assign idx  = rs_idx[gp*RW +: RW];
        assign mtag = tag[idx];

        // Scan high to low so the lowest matching channel wins.
        always_comb begin
            cdb_hit = 1'b0;
            cdb_v   = '0;
            for (int c = NCDB - 1; c >= 0; c--) begin
                if (cdb_flag[c] && cdb_tag[c*TAG_W +: TAG_W] == mtag) begin
                    cdb_hit = 1'b1;
                    cdb_v   = cdb_val[c*XLEN +: XLEN];
                end
            end
        end

        always_comb begin
            ok  = 1'b1;
            val = '0;
            if (idx == '0) begin
                val = '0;
            end else if (!busy[idx]) begin
                val = reg_val[idx];
            end else if (rob_q_rdy[gp]) begin
                val = rob_q_val[gp*XLEN +: XLEN];
            end else if (cdb_hit) begin
                val = cdb_v;
            end else if (cmt_flag && cmt_tag == mtag) begin
                val = cmt_val;
            end else begin
                ok = 1'b0;
            end
        end

        assign rs_val[gp*XLEN +: XLEN]     = val;
        assign rs_rdy[gp]                  = ok;
        assign rs_tag[gp*TAG_W +: TAG_W]   = mtag;
        assign rob_q_tag[gp*TAG_W +: TAG_W] = mtag;
    end

    // ---------------- checkpoint slot allocation ----------------
    always_comb begin
        free_id = '0;
        for (int j = NCKPT - 1; j >= 0; j--) begin
            if (!ck_valid[j]) free_id = CK_W'(j);
        end
    end

    assign ckpt_id   = free_id;
    assign ckpt_full = &ck_valid;
    assign rnm_en    = rnm_flag && !ckpt_restore && !flush && (rnm_rd != '0);
    assign save_en   = ckpt_save && !ckpt_full && !ckpt_restore && !flush;
    assign rel_mask  = ckpt_release ? ((NCKPT'(1) << ckpt_release_id) & ck_valid) : '0;

    // ---------------- next live map ----------------
    always_comb begin
        busy_n = '0;
        for (int i = 0; i < NREG; i++) begin
            tag_n[i] = tag[i];
            if (ckpt_restore) begin
                tag_n[i]  = ck_tag[ckpt_restore_id][i];
                busy_n[i] = ck_busy[ckpt_restore_id][i] &&
                            !(cmt_flag && cmt_rd == RW'(i) &&
                              ck_tag[ckpt_restore_id][i] == cmt_tag);
            end else begin
                busy_n[i] = busy[i] && !(cmt_flag && cmt_rd == RW'(i) && tag[i] == cmt_tag);
            end
            if (rnm_en && rnm_rd == RW'(i)) begin
                busy_n[i] = 1'b1;
                tag_n[i]  = rnm_tag;
            end
            if (flush) begin
                busy_n[i] = 1'b0;
                tag_n[i]  = '0;
            end
        end
        busy_n[0] = 1'b0;
        tag_n[0]  = '0;
    end

    // ---------------- next checkpoint state ----------------
    always_comb begin
        valid_n = ck_valid;
        if (ckpt_restore) valid_n = ck_valid & ck_older[ckpt_restore_id];
        if (save_en) valid_n[free_id] = 1'b1;
        valid_n = valid_n & ~rel_mask;
        if (flush) valid_n = '0;

        for (int j = 0; j < NCKPT; j++) begin
            older_n[j]   = ck_older[j] & ~rel_mask;
            ck_busy_n[j] = ck_busy[j];
            for (int i = 0; i < NREG; i++) ck_tag_n[j][i] = ck_tag[j][i];
            // Retire the committing producer from every live snapshot too.
            if (ck_valid[j] && cmt_flag && ck_tag[j][cmt_rd] == cmt_tag)
                ck_busy_n[j][cmt_rd] = 1'b0;
            if (save_en && free_id == CK_W'(j)) begin
                older_n[j]   = ck_valid & ~rel_mask;
                ck_busy_n[j] = busy_n;
                for (int i = 0; i < NREG; i++) ck_tag_n[j][i] = tag_n[i];
            end
            if (flush) older_n[j] = '0;
        end
    end

    // ---------------- state update ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            ck_valid <= '0;
            for (int i = 0; i < NREG; i++) begin
                reg_val[i] <= '0;
                tag[i]     <= '0;
            end
            for (int j = 0; j < NCKPT; j++) begin
                ck_older[j] <= '0;
                ck_busy[j]  <= '0;
                for (int i = 0; i < NREG; i++) ck_tag[j][i] <= '0;
            end
        end else if (rdy) begin
            if (cmt_flag && cmt_rd != '0) reg_val[cmt_rd] <= cmt_val;
            busy     <= busy_n;
            ck_valid <= valid_n;
            for (int i = 0; i < NREG; i++) tag[i] <= tag_n[i];
            for (int j = 0; j < NCKPT; j++) begin
                ck_older[j] <= older_n[j];
                ck_busy[j]  <= ck_busy_n[j];
                for (int i = 0; i < NREG; i++) ck_tag[j][i] <= ck_tag_n[j][i];
            end
        end
    end

endmodule

// File: doc/rename_reg_file_ckpt.md
Name: rename_reg_file_ckpt

Overview:
- Architectural register file plus register alias table (busy bit + ROB tag per register) for the Tomasulo core.
- Parametrised successor of the single-snapshot-less rename file: configurable XLEN, register count, ROB tag width, read-port count and CDB count.
- Adds NCKPT branch checkpoints of the rename map, so a mispredict restores the map selectively instead of clearing it.
- Sits between decode/issue (reads, renames, checkpoints), the CDB/ROB (wakeup, commit) and branch resolution (restore/release).

Parameters:
XLEN, 32, data width
NREG, 32, architectural registers; index width RW = clog2(NREG)
TAG_W, 4, ROB index width
NRP, 2, source read ports
NCDB, 2, CDB broadcast channels
NCKPT, 4, checkpoint slots; CK_W = clog2(NCKPT)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global enable; low freezes all state
flush  in  1  full pipeline flush
rs_idx  in  NRP*RW  source register per port
rs_val  out  NRP*XLEN  operand value; 0 when not ready
rs_rdy  out  NRP  operand ready
rs_tag  out  NRP*TAG_W  producing ROB tag when not ready
rob_q_tag  out  NRP*TAG_W  ROB lookup tag per port (map tag of rs_idx)
rob_q_rdy  in  NRP  ROB entry has result
rob_q_val  in  NRP*XLEN  ROB result
cdb_flag  in  NCDB  broadcast valid
cdb_tag  in  NCDB*TAG_W  broadcast tag
cdb_val  in  NCDB*XLEN  broadcast value
cmt_flag  in  1  commit valid
cmt_rd  in  RW  commit destination
cmt_tag  in  TAG_W  committing tag
cmt_val  in  XLEN  commit value
rnm_flag  in  1  rename request
rnm_rd  in  RW  renamed destination
rnm_tag  in  TAG_W  new producer tag
ckpt_save  in  1  allocate checkpoint
ckpt_id  out  CK_W  slot a save this cycle gets
ckpt_full  out  1  no free slot
ckpt_restore  in  1  mispredict
ckpt_restore_id  in  CK_W  slot to restore
ckpt_release  in  1  branch resolved correct
ckpt_release_id  in  CK_W  slot to free

Behaviour:
- Reset (rst low, async): reg_val, busy, tags, slot valid and older-masks all 0. Resulting outputs: ckpt_full=0, ckpt_id=0, every rs_rdy=1, rs_val=0.
- Reads are combinational, zero latency, and see the pre-update state of this cycle.
- Read priority per port:
  - rs_idx==0: 0, ready.
  - Not busy: reg_val.
  - rob_q_rdy: rob_q_val.
  - CDB match: lowest-index channel with cdb_flag and equal tag.
  - Commit match on tag.
  - Otherwise rs_rdy=0, rs_val=0, rs_tag = map tag.
- Commit:
  - reg_val[cmt_rd] <= cmt_val.
  - Live busy cleared only if the entry is busy with tag==cmt_tag.
  - A same-cycle rename of the same rd wins (stays busy with rnm_tag).
  - The same clear is applied to the matching entry in every valid checkpoint.
- Rename: busy[rnm_rd] <= 1, tag <= rnm_tag. Ignored in a restore or flush cycle.
- Save:
  - ckpt_id is the lowest free slot.
  - If ckpt_save and not full: slot valid, map snapshot = next-state live map (after this cycle's commit and rename), older-mask = current valid set.
  - Save when full is ignored.
- Release: clear valid of slot; clear that bit in all older-masks. Releasing an invalid slot is a no-op.
- Restore of slot k:
  - Live map <= slot k snapshot, with this cycle's commit clear applied.
  - Free k and every valid slot not in k's older-mask (younger branches).
  - Save and rename in the same cycle are ignored.
  - A release of a freed slot in the same cycle is harmless.
- Flush: busy=0, tags=0, all slots freed; reg_val keeps commit writes. Flush overrides restore, save and rename.
- Priority: rst > !rdy (hold) > flush > restore > commit/rename/save/release.
- x0 is always value 0, never busy, and never renamed in live or snapshot maps.
- ckpt_full = all NCKPT slots valid.

Test Plan:
- Reset, then read x5 and x0 -> rs_rdy=1, rs_val=0; ckpt_full=0, ckpt_id=0.
- Rename x5->tag 3; next cycle read x5 with cdb_flag[1]=1, tag 3, val 0xABCD -> rs_val=0xABCD, rs_rdy=1. Without the CDB hit -> rs_rdy=0, rs_tag=3.
- Rename x7->tag 2; save (slot 0); rename x7->tag 6; restore slot 0 -> x7 busy, tag 2. Then commit x7/tag 2, val 9 -> x7 ready, value 9.
- Four saves -> ckpt_full=1; fifth save ignored. Restore slot 1 -> slots 1,2,3 freed, slot 0 valid, ckpt_id=1.
- Same cycle: commit x4/tag 1 and rename x4->tag 5 -> reg_val[x4] updated, x4 busy with tag 5.
- Assert flush with rdy=0 -> no change. Then rdy=1 -> all registers ready, all slots free, reg_val retained.
